// File: rtl/amo_lrsc_shim.sv
// -----------------------------------------------------------------------------
// amo_lrsc_shim
//
// Atomic memory shim placed in front of a single SRAM bank (it must be the
// bank's only master). Plain loads/stores pass straight through. RISC-V AMOs
// are executed as a read (grant cycle) followed by a write-back one cycle
// later on a single 32-bit lane. LR/SC reservations are tracked per requester
// ID in a small table. Every granted request gets a registered response one
// cycle after the grant.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   in_req_i/in_gnt_o   request / grant from the interconnect
//   in_add_i            bank word address
//   in_amo_i            op: 0 none, 1..9 AMO, A LR, B SC, C..F as 0
//   in_wen_i            store (1) / load (0), only for op 0
//   in_wdata_i, in_be_i write data / operand, byte enables
//   in_id_i             requester ID
//   in_rvalid_o, in_rid_o, in_rdata_o   response channel
//   out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o   SRAM request
//   out_rdata_i         SRAM read data (one cycle after a read)
// -----------------------------------------------------------------------------
module amo_lrsc_shim #(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned NumRes       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_req_i,
    output logic                    in_gnt_o,
    input  logic [AddrMemWidth-1:0] in_add_i,
    input  logic [3:0]              in_amo_i,
    input  logic                    in_wen_i,
    input  logic [DataWidth-1:0]    in_wdata_i,
    input  logic [DataWidth/8-1:0]  in_be_i,
    input  logic [IdWidth-1:0]      in_id_i,
    output logic                    in_rvalid_o,
    output logic [IdWidth-1:0]      in_rid_o,
    output logic [DataWidth-1:0]    in_rdata_o,
    output logic                    out_req_o,
    output logic [AddrMemWidth-1:0] out_add_o,
    output logic                    out_wen_o,
    output logic [DataWidth-1:0]    out_wdata_o,
    output logic [DataWidth/8-1:0]  out_be_o,
    input  logic [DataWidth-1:0]    out_rdata_i
);

    localparam int unsigned NB = DataWidth / 8;
    localparam int unsigned NL = DataWidth / 32;
    localparam int unsigned LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int unsigned VW = (NumRes > 1) ? $clog2(NumRes) : 1;

    if (!(DataWidth == 32 || DataWidth == 64 || DataWidth == 128 || DataWidth == 256)) begin : g_bad_dw
        $fatal(1, "amo_lrsc_shim: DataWidth must be 32, 64, 128 or 256");
    end
    if (NumRes < 1) begin : g_bad_nr
        $fatal(1, "amo_lrsc_shim: NumRes must be at least 1");
    end

    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_SWAP = 4'h1,
        AMO_ADD  = 4'h2,
        AMO_AND  = 4'h3,
        AMO_OR   = 4'h4,
        AMO_XOR  = 4'h5,
        AMO_MAX  = 4'h6,
        AMO_MAXU = 4'h7,
        AMO_MIN  = 4'h8,
        AMO_MINU = 4'h9,
        AMO_LR   = 4'hA,
        AMO_SC   = 4'hB
    } amo_op_e;

    typedef enum logic {
        S_IDLE,
        S_DOAMO
    } state_e;

    // Lane = (index of lowest set byte enable) / 4; iterating downwards lets
    // the lowest set bit win.
    function automatic logic [LW-1:0] f_lane(input logic [NB-1:0] be);
        logic [LW-1:0] lane;
        lane = '0;
        for (int unsigned i = NB; i > 0; i--) begin
            if (be[i-1]) lane = LW'((i - 1) / 4);
        end
        return lane;
    endfunction

    function automatic logic [NB-1:0] f_lane_be(input logic [LW-1:0] lane);
        logic [NB-1:0] be;
        be = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (lane == LW'(i)) be[4*i +: 4] = 4'hF;
        end
        return be;
    endfunction

    // ---------------------------------------------------------------- state
    state_e                  r_state;
    state_e                  w_state_nxt;

    logic [3:0]              r_op;
    logic [AddrMemWidth-1:0] r_add;
    logic [LW-1:0]           r_lane;
    logic [31:0]             r_operand;

    logic                    r_rvalid;
    logic [IdWidth-1:0]      r_rid;
    logic                    r_sc_rsp;
    logic                    r_sc_fail;
    logic [LW-1:0]           r_sc_lane;

    logic                    r_res_valid [NumRes];
    logic [IdWidth-1:0]      r_res_id    [NumRes];
    logic [AddrMemWidth-1:0] r_res_add   [NumRes];
    logic [LW-1:0]           r_res_lane  [NumRes];
    logic [VW-1:0]           r_victim;

    // ---------------------------------------------------------------- decode
    logic          w_is_amo;
    logic          w_is_lr;
    logic          w_is_sc;
    logic          w_xfer;
    logic [LW-1:0] w_lane;
    logic [31:0]   w_operand;

    assign w_is_amo = (in_amo_i >= AMO_SWAP) && (in_amo_i <= AMO_MINU);
    assign w_is_lr  = (in_amo_i == AMO_LR);
    assign w_is_sc  = (in_amo_i == AMO_SC);
    assign w_xfer   = in_req_i & in_gnt_o;
    assign w_lane   = f_lane(in_be_i);

    always_comb begin
        w_operand = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (w_lane == LW'(i)) w_operand = in_wdata_i[32*i +: 32];
        end
    end

    // ------------------------------------------------------ reservation lookup
    logic          w_id_hit;
    logic          w_id_multi;
    logic [VW-1:0] w_id_idx;
    logic          w_free;
    logic [VW-1:0] w_free_idx;
    logic          w_sc_ok;
    logic [VW-1:0] w_lr_idx;
    logic          w_lr_evict;

    always_comb begin
        w_id_hit   = 1'b0;
        w_id_multi = 1'b0;
        w_id_idx   = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int unsigned i = 0; i < NumRes; i++) begin
            if (r_res_valid[i] && r_res_id[i] == in_id_i) begin
                if (w_id_hit) w_id_multi = 1'b1;
                w_id_hit = 1'b1;
                w_id_idx = VW'(i);
            end
            if (!r_res_valid[i] && !w_free) begin
                w_free     = 1'b1;
                w_free_idx = VW'(i);
            end
        end
        w_sc_ok    = w_id_hit && (r_res_add[w_id_idx] == in_add_i)
                              && (r_res_lane[w_id_idx] == w_lane);
        w_lr_evict = !w_id_hit && !w_free;
        if (w_id_hit)    w_lr_idx = w_id_idx;
        else if (w_free) w_lr_idx = w_free_idx;
        else             w_lr_idx = r_victim;
    end

    // ------------------------------------------------------------------- ALU
    logic [31:0]          w_old;
    logic [31:0]          w_res;
    logic [DataWidth-1:0] w_amo_wdata;

    always_comb begin
        w_old = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (r_lane == LW'(i)) w_old = out_rdata_i[32*i +: 32];
        end
        case (r_op)
            AMO_ADD:  w_res = w_old + r_operand;
            AMO_AND:  w_res = w_old & r_operand;
            AMO_OR:   w_res = w_old | r_operand;
            AMO_XOR:  w_res = w_old ^ r_operand;
            AMO_MAX:  w_res = ($signed(w_old) > $signed(r_operand)) ? w_old : r_operand;
            AMO_MAXU: w_res = (w_old > r_operand) ? w_old : r_operand;
            AMO_MIN:  w_res = ($signed(w_old) < $signed(r_operand)) ? w_old : r_operand;
            AMO_MINU: w_res = (w_old < r_operand) ? w_old : r_operand;
            default:  w_res = r_operand;
        endcase
        w_amo_wdata = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (r_lane == LW'(i)) w_amo_wdata[32*i +: 32] = w_res;
        end
    end

    // ----------------------------------------------- FSM next state / outputs
    always_comb begin
        w_state_nxt = r_state;
        in_gnt_o    = 1'b0;
        out_req_o   = 1'b0;
        out_add_o   = in_add_i;
        out_wen_o   = 1'b0;
        out_wdata_o = in_wdata_i;
        out_be_o    = in_be_i;
        case (r_state)
            S_IDLE: begin
                in_gnt_o = in_req_i;
                if (w_is_amo) begin
                    out_req_o = in_req_i;
                    if (in_req_i) w_state_nxt = S_DOAMO;
                end else if (w_is_lr) begin
                    out_req_o = in_req_i;
                end else if (w_is_sc) begin
                    // A failed SC never reaches the bank.
                    out_req_o = in_req_i & w_sc_ok;
                    out_wen_o = 1'b1;
                    out_be_o  = f_lane_be(w_lane);
                end else begin
                    out_req_o = in_req_i;
                    out_wen_o = in_wen_i;
                end
            end
            S_DOAMO: begin
                out_req_o   = 1'b1;
                out_wen_o   = 1'b1;
                out_add_o   = r_add;
                out_be_o    = f_lane_be(r_lane);
                out_wdata_o = w_amo_wdata;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ------------------------------------------------------ AMO operand latch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op      <= '0;
            r_add     <= '0;
            r_lane    <= '0;
            r_operand <= '0;
        end else if (w_xfer && w_is_amo) begin
            r_op      <= in_amo_i;
            r_add     <= in_add_i;
            r_lane    <= w_lane;
            r_operand <= w_operand;
        end
    end

    // -------------------------------------------------------------- response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_sc_rsp  <= 1'b0;
            r_sc_fail <= 1'b0;
            r_sc_lane <= '0;
        end else begin
            r_rvalid <= w_xfer;
            r_sc_rsp <= w_xfer & w_is_sc;
            if (w_xfer) begin
                r_rid     <= in_id_i;
                r_sc_fail <= !w_sc_ok;
                r_sc_lane <= w_lane;
            end
        end
    end

    assign in_rvalid_o = r_rvalid;
    assign in_rid_o    = r_rid;

    always_comb begin
        in_rdata_o = out_rdata_i;
        if (r_sc_rsp) begin
            in_rdata_o = '0;
            for (int unsigned i = 0; i < NL; i++) begin
                if (r_sc_lane == LW'(i)) in_rdata_o[32*i] = r_sc_fail;
            end
        end
    end

    // ------------------------------------------------------ reservation table
    logic w_wr;
    assign w_wr = out_req_o & out_wen_o;

    // Invalidations and LR allocation never target the same cycle: an LR is a
    // read and occupies the single bank port, so the update order is free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumRes; i++) begin
                r_res_valid[i] <= 1'b0;
                r_res_id[i]    <= '0;
                r_res_add[i]   <= '0;
                r_res_lane[i]  <= '0;
            end
            r_victim <= '0;
        end else begin
            for (int unsigned i = 0; i < NumRes; i++) begin
                if (w_wr && r_res_valid[i] && r_res_add[i] == out_add_o) r_res_valid[i] <= 1'b0;
            end
            if (w_xfer && w_is_sc && w_id_hit) r_res_valid[w_id_idx] <= 1'b0;
            if (w_xfer && w_is_lr) begin
                r_res_valid[w_lr_idx] <= 1'b1;
                r_res_id[w_lr_idx]    <= in_id_i;
                r_res_add[w_lr_idx]   <= in_add_i;
                r_res_lane[w_lr_idx]  <= w_lane;
                if (w_lr_evict) begin
                    r_victim <= (r_victim == VW'(NumRes - 1)) ? '0 : r_victim + 1'b1;
                end
            end
        end
    end

    a_one_slot_per_id : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_id_multi);

endmodule

// File: tb/tb_amo_lrsc_shim.sv
module tb_amo_lrsc_shim;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int NR = 2;

    logic          clk;
    logic          rst_n;
    logic          in_req_i;
    logic          in_gnt_o;
    logic [AW-1:0] in_add_i;
    logic [3:0]    in_amo_i;
    logic          in_wen_i;
    logic [DW-1:0] in_wdata_i;
    logic [7:0]    in_be_i;
    logic [IW-1:0] in_id_i;
    logic          in_rvalid_o;
    logic [IW-1:0] in_rid_o;
    logic [DW-1:0] in_rdata_o;
    logic          out_req_o;
    logic [AW-1:0] out_add_o;
    logic          out_wen_o;
    logic [DW-1:0] out_wdata_o;
    logic [7:0]    out_be_o;
    logic [DW-1:0] sram_rd;

    amo_lrsc_shim #(
        .AddrMemWidth(AW),
        .DataWidth   (DW),
        .IdWidth     (IW),
        .NumRes      (NR)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_req_i   (in_req_i),
        .in_gnt_o   (in_gnt_o),
        .in_add_i   (in_add_i),
        .in_amo_i   (in_amo_i),
        .in_wen_i   (in_wen_i),
        .in_wdata_i (in_wdata_i),
        .in_be_i    (in_be_i),
        .in_id_i    (in_id_i),
        .in_rvalid_o(in_rvalid_o),
        .in_rid_o   (in_rid_o),
        .in_rdata_o (in_rdata_o),
        .out_req_o  (out_req_o),
        .out_add_o  (out_add_o),
        .out_wen_o  (out_wen_o),
        .out_wdata_o(out_wdata_o),
        .out_be_o   (out_be_o),
        .out_rdata_i(sram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int unsigned i);
        return {32'(i) * 32'h9E37_79B9 + 32'h1111_1111, 32'(i) * 32'h85EB_CA6B + 32'h0BAD_F00D};
    endfunction

    // Behavioural SRAM bank (16 words) driven by the shim.
    logic [63:0] sram [16];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
        end else if (out_req_o) begin
            if (out_wen_o) begin
                for (int b = 0; b < 8; b++)
                    if (out_be_o[b]) sram[out_add_o[3:0]][8*b +: 8] <= out_wdata_o[8*b +: 8];
            end else begin
                sram_rd <= sram[out_add_o[3:0]];
            end
        end
    end

    // ---------------------------------------------------- reference model
    logic [63:0] m_mem [16];
    logic        m_v    [NR];
    logic [3:0]  m_id   [NR];
    int unsigned m_add  [NR];
    int unsigned m_lane [NR];
    int unsigned m_victim;

    int n_checks = 0;
    int n_pass   = 0;

    logic        g, rv, dg, dwen, chk;
    logic [3:0]  rid;
    logic [63:0] rd, dwd, exp_rd, exp_wd;
    logic [7:0]  dbe, exp_be;

    function automatic int unsigned lane_of(input logic [7:0] be);
        for (int b = 0; b < 8; b++) if (be[b]) return b / 4;
        return 0;
    endfunction

    task automatic mdl_clear_res();
        for (int s = 0; s < NR; s++) m_v[s] = 1'b0;
        m_victim = 0;
    endtask

    task automatic mdl_kill_addr(input int unsigned add);
        for (int s = 0; s < NR; s++) if (m_v[s] && m_add[s] == add) m_v[s] = 1'b0;
    endtask

    // One transaction at the level of "what the bank and reservation set look
    // like afterwards". exp_wd/exp_be describe an AMO's write-back beat.
    task automatic mdl_step(input logic [3:0] op, input logic wen, input int unsigned add,
                            input logic [63:0] wd, input logic [7:0] be, input logic [3:0] id,
                            output logic [63:0] erd, output logic echk,
                            output logic [63:0] ewd, output logic [7:0] ebe);
        int unsigned L;
        int          hit;
        int          s;
        logic [63:0] word;
        logic [31:0] oldv, opd, res;
        logic        ok;
        L    = lane_of(be);
        word = m_mem[add];
        oldv = word[32*L +: 32];
        opd  = wd[32*L +: 32];
        erd  = word;
        echk = 1'b1;
        ewd  = '0;
        ebe  = '0;
        hit  = -1;
        for (int k = 0; k < NR; k++) if (m_v[k] && m_id[k] == id) hit = k;
        if (op >= 4'h1 && op <= 4'h9) begin
            case (op)
                4'h1: res = opd;
                4'h2: res = oldv + opd;
                4'h3: res = oldv & opd;
                4'h4: res = oldv | opd;
                4'h5: res = oldv ^ opd;
                4'h6: res = ($signed(oldv) > $signed(opd)) ? oldv : opd;
                4'h7: res = (oldv > opd) ? oldv : opd;
                4'h8: res = ($signed(oldv) < $signed(opd)) ? oldv : opd;
                default: res = (oldv < opd) ? oldv : opd;
            endcase
            word[32*L +: 32] = res;
            m_mem[add] = word;
            ewd[32*L +: 32] = res;
            ebe[4*L +: 4]   = 4'hF;
            mdl_kill_addr(add);
        end else if (op == 4'hA) begin
            if (hit >= 0) s = hit;
            else begin
                s = -1;
                for (int k = NR - 1; k >= 0; k--) if (!m_v[k]) s = k;
                if (s < 0) begin
                    s = int'(m_victim);
                    m_victim = (m_victim + 1) % NR;
                end
            end
            m_v[s] = 1'b1; m_id[s] = id; m_add[s] = add; m_lane[s] = L;
        end else if (op == 4'hB) begin
            ok = (hit >= 0) && m_add[hit] == add && m_lane[hit] == L;
            if (hit >= 0) m_v[hit] = 1'b0;
            if (ok) begin
                word[32*L +: 32] = opd;
                m_mem[add] = word;
                mdl_kill_addr(add);
            end
            erd = '0;
            erd[32*L] = !ok;
        end else if (wen) begin
            for (int b = 0; b < 8; b++) if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
            m_mem[add] = word;
            mdl_kill_addr(add);
            echk = 1'b0;
        end
    endtask

    // Drives one request and captures what the DUT shows; compares nothing.
    task automatic xact(input logic [3:0] op, input logic wen, input int unsigned add,
                        input logic [63:0] wd, input logic [7:0] be, input logic [3:0] id);
        @(posedge clk); #1;
        in_req_i = 1'b1; in_amo_i = op; in_wen_i = wen; in_add_i = add;
        in_wdata_i = wd; in_be_i = be; in_id_i = id;
        #1 g = in_gnt_o;
        @(posedge clk); #1;
        rv = in_rvalid_o; rid = in_rid_o; rd = in_rdata_o;
        dg = in_gnt_o; dbe = out_be_o; dwd = out_wdata_o; dwen = out_req_o & out_wen_o;
        in_req_i = 1'b0;
    endtask

    task automatic step(input logic [3:0] op, input logic wen, input int unsigned add,
                        input logic [63:0] wd, input logic [7:0] be, input logic [3:0] id);
        mdl_step(op, wen, add, wd, be, id, exp_rd, chk, exp_wd, exp_be);
        xact(op, wen, add, wd, be, id);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; in_req_i = 1'b0; in_amo_i = '0; in_wen_i = 1'b0; in_add_i = '0;
        in_wdata_i = '0; in_be_i = '0; in_id_i = '0; mem_init = 1'b1;
        for (int i = 0; i < 16; i++) m_mem[i] = init_word(i);
        mdl_clear_res();
        #2;
        n_checks++; if (in_rvalid_o !== 1'b0) $display("FAIL reset_rvalid got %b want 0", in_rvalid_o); else n_pass++;
        n_checks++; if (in_rid_o !== 4'h0) $display("FAIL reset_rid got %h want 0", in_rid_o); else n_pass++;
        n_checks++; if ({in_gnt_o, out_req_o} !== 2'b00) $display("FAIL reset_idle_req got %b want 00", {in_gnt_o, out_req_o}); else n_pass++;
        in_req_i = 1'b1;
        #1;
        n_checks++; if ({in_gnt_o, out_req_o} !== 2'b11) $display("FAIL reset_follow_req got %b want 11", {in_gnt_o, out_req_o}); else n_pass++;
        in_req_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; mem_init = 1'b0;
    endtask

    task automatic test_plain();
        step(4'h0, 1'b1, 3, 64'h0000_0000_0000_00A5, 8'h0F, 4'h1);
        n_checks++; if (g !== 1'b1) $display("FAIL store_gnt got %b want 1", g); else n_pass++;
        step(4'h0, 1'b0, 3, 64'h0, 8'hFF, 4'h6);
        n_checks++; if (g !== 1'b1) $display("FAIL load_gnt got %b want 1", g); else n_pass++;
        n_checks++; if (rv !== 1'b1 || rid !== 4'h6) $display("FAIL load_rsp got rv=%b id=%h want rv=1 id=6", rv, rid); else n_pass++;
        n_checks++; if (rd[31:0] !== 32'h0000_00A5) $display("FAIL load_a5 got %h want 000000a5", rd[31:0]); else n_pass++;
        n_checks++; if (rd !== exp_rd) $display("FAIL load_word got %h want %h", rd, exp_rd); else n_pass++;
    endtask

    task automatic test_amo_add();
        step(4'h0, 1'b1, 5, 64'hFFFF_FFFF_0000_0000, 8'hFF, 4'h0);
        step(4'h2, 1'b0, 5, 64'h0000_0002_0000_0000, 8'hF0, 4'h4);
        n_checks++; if (rd[63:32] !== 32'hFFFF_FFFF) $display("FAIL amoadd_old got %h want ffffffff", rd[63:32]); else n_pass++;
        n_checks++; if (rv !== 1'b1 || rid !== 4'h4) $display("FAIL amoadd_rsp got rv=%b id=%h want rv=1 id=4", rv, rid); else n_pass++;
        n_checks++; if (dg !== 1'b0) $display("FAIL amoadd_gnt_doamo got %b want 0", dg); else n_pass++;
        n_checks++; if (dwen !== 1'b1 || dbe !== 8'hF0) $display("FAIL amoadd_wb_be got wen=%b be=%h want wen=1 be=f0", dwen, dbe); else n_pass++;
        n_checks++; if (dwd !== 64'h0000_0001_0000_0000) $display("FAIL amoadd_wb_data got %h want 0000000100000000", dwd); else n_pass++;
        step(4'h0, 1'b0, 5, 64'h0, 8'hFF, 4'h0);
        n_checks++; if (rd !== exp_rd || rd[63:32] !== 32'h1) $display("FAIL amoadd_mem got %h want %h", rd, exp_rd); else n_pass++;
    endtask

    task automatic test_signed();
        step(4'h0, 1'b1, 4, 64'h0000_0000_8000_0000, 8'h0F, 4'h0);
        step(4'h6, 1'b0, 4, 64'h1, 8'h0F, 4'h0);
        step(4'h0, 1'b0, 4, 64'h0, 8'hFF, 4'h0);
        n_checks++; if (rd[31:0] !== 32'h1) $display("FAIL amomax_signed got %h want 00000001", rd[31:0]); else n_pass++;
        step(4'h0, 1'b1, 4, 64'h0000_0000_8000_0000, 8'h0F, 4'h0);
        step(4'h7, 1'b0, 4, 64'h1, 8'h0F, 4'h0);
        step(4'h0, 1'b0, 4, 64'h0, 8'hFF, 4'h0);
        n_checks++; if (rd[31:0] !== 32'h8000_0000) $display("FAIL amomaxu got %h want 80000000", rd[31:0]); else n_pass++;
    endtask

    task automatic test_lrsc();
        step(4'hA, 1'b0, 7, 64'h0, 8'h0F, 4'h2);
        n_checks++; if (rd !== exp_rd || rv !== 1'b1) $display("FAIL lr_read got %h rv=%b want %h rv=1", rd, rv, exp_rd); else n_pass++;
        step(4'hB, 1'b0, 7, 64'h55, 8'h0F, 4'h2);
        n_checks++; if (rd !== 64'h0 || rid !== 4'h2) $display("FAIL sc_pass got %h id=%h want 0 id=2", rd, rid); else n_pass++;
        step(4'h0, 1'b0, 7, 64'h0, 8'hFF, 4'h2);
        n_checks++; if (rd[31:0] !== 32'h55 || rd !== exp_rd) $display("FAIL sc_pass_mem got %h want %h", rd, exp_rd); else n_pass++;
        step(4'hB, 1'b0, 7, 64'h66, 8'h0F, 4'h2);
        n_checks++; if (rd !== 64'h1) $display("FAIL sc_again got %h want 1", rd); else n_pass++;
        step(4'hA, 1'b0, 7, 64'h0, 8'h0F, 4'h2);
        step(4'h0, 1'b1, 7, 64'h1234, 8'hFF, 4'h1);
        step(4'hB, 1'b0, 7, 64'h77, 8'h0F, 4'h2);
        n_checks++; if (rd !== 64'h1) $display("FAIL sc_after_store got %h want 1", rd); else n_pass++;
        step(4'h0, 1'b0, 7, 64'h0, 8'hFF, 4'h2);
        n_checks++; if (rd !== 64'h1234) $display("FAIL sc_fail_nowrite got %h want 1234", rd); else n_pass++;
    endtask

    task automatic test_evict();
        step(4'hA, 1'b0, 10, 64'h0, 8'h0F, 4'h1);
        step(4'hA, 1'b0, 11, 64'h0, 8'h0F, 4'h2);
        step(4'hA, 1'b0, 12, 64'h0, 8'h0F, 4'h3);
        step(4'hB, 1'b0, 10, 64'hAA, 8'h0F, 4'h1);
        n_checks++; if (rd !== 64'h1) $display("FAIL evict_sc_id1 got %h want 1", rd); else n_pass++;
        step(4'hB, 1'b0, 12, 64'hBB, 8'h0F, 4'h3);
        n_checks++; if (rd !== 64'h0) $display("FAIL evict_sc_id3 got %h want 0", rd); else n_pass++;
        step(4'hB, 1'b0, 11, 64'hCC, 8'hF0, 4'h2);
        n_checks++; if (rd !== 64'h0000_0001_0000_0000) $display("FAIL sc_wrong_lane got %h want 0000000100000000", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_amo();
        step(4'hA, 1'b0, 7, 64'h0, 8'h0F, 4'h2);
        @(posedge clk); #1;
        in_req_i = 1'b1; in_amo_i = 4'h2; in_wen_i = 1'b0; in_add_i = 9;
        in_wdata_i = 64'h1; in_be_i = 8'h0F; in_id_i = 4'h3;
        @(posedge clk); #1;
        rst_n = 1'b0; in_req_i = 1'b0;
        #1;
        n_checks++; if (in_rvalid_o !== 1'b0) $display("FAIL midamo_rvalid got %b want 0", in_rvalid_o); else n_pass++;
        n_checks++; if (out_req_o !== 1'b0) $display("FAIL midamo_outreq got %b want 0", out_req_o); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (in_rvalid_o !== 1'b0) $display("FAIL midamo_rvalid_hold got %b want 0", in_rvalid_o); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_clear_res();
        step(4'hB, 1'b0, 7, 64'h99, 8'h0F, 4'h2);
        n_checks++; if (rd !== 64'h1) $display("FAIL midamo_sc got %h want 1", rd); else n_pass++;
        step(4'h0, 1'b0, 9, 64'h0, 8'hFF, 4'h0);
        n_checks++; if (rd !== init_word(9)) $display("FAIL midamo_nowrite got %h want %h", rd, init_word(9)); else n_pass++;
    endtask

    task automatic test_random();
        int unsigned k, add;
        logic [3:0]  op, id;
        logic        wen;
        logic [7:0]  be;
        logic [63:0] wd;
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 13);
            op = 4'h0; wen = 1'b0;
            case (k)
                0: ;
                1: wen = 1'b1;
                11: op = 4'hA;
                12: op = 4'hB;
                13: begin op = 4'(12 + $urandom_range(0, 3)); wen = 1'($urandom_range(0, 1)); end
                default: op = 4'(k - 1);
            endcase
            add = $urandom_range(0, 3);
            id  = 4'($urandom_range(0, 3));
            be  = 8'($urandom_range(1, 255));
            wd  = {$urandom, $urandom};
            step(op, wen, add, wd, be, id);
            n_checks++; if (g !== 1'b1 || rv !== 1'b1 || rid !== id) $display("FAIL rnd_hs n=%0d got g=%b rv=%b id=%h want 1 1 %h", n, g, rv, rid, id); else n_pass++;
            if (chk) begin
                n_checks++; if (rd !== exp_rd) $display("FAIL rnd_rdata n=%0d op=%h got %h want %h", n, op, rd, exp_rd); else n_pass++;
            end
            if (op >= 4'h1 && op <= 4'h9) begin
                n_checks++;
                if (dg !== 1'b0 || dwen !== 1'b1 || dbe !== exp_be || dwd !== exp_wd)
                    $display("FAIL rnd_wb n=%0d got g=%b w=%b be=%h d=%h want 0 1 %h %h", n, dg, dwen, dbe, dwd, exp_be, exp_wd);
                else n_pass++;
            end
        end
        for (int unsigned a = 0; a < 4; a++) begin
            step(4'h0, 1'b0, a, 64'h0, 8'hFF, 4'h0);
            n_checks++; if (rd !== exp_rd) $display("FAIL rnd_final w%0d got %h want %h", a, rd, exp_rd); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_amo_add();
        test_signed();
        test_lrsc();
        test_evict();
        test_reset_mid_amo();
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
